uart_boot_loader: RTL and testbench

- Upstream feeder of the instruction memory: receives a program image over the board UART and writes it word-by-word into the 2048-word instruction memory, replacing the file preload at run time.
- Holds the CPU in reset while a load is in progress.
- Releases the CPU on a verified load, so execution restarts at PC 0 with the new image.
- Contains its own 8N1 UART receiver.

---
 rtl/uart_boot_loader.sv | 333 +++++++++++++++++++++++++++++++++
 tb/tb_uart_boot_loader.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_boot_loader.sv
// UART program loader: receives SYNC/count/words/checksum and writes the image into instruction memory.
// Define BOOT_ECHO_EN to build the 8N1 echo transmitter on uart_tx; otherwise uart_tx is tied high.
module uart_boot_loader #(
   parameter int unsigned CLK_FREQ  = 100000000,
   parameter int unsigned BAUD      = 115200,
   parameter int unsigned ADDR_W    = 11,
   parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              uart_rx,
   output logic              uart_tx,
   output logic              imem_we,
   output logic [ADDR_W-1:0] imem_waddr,
   output logic [31:0]       imem_wdata,
   output logic              cpu_hold,
   output logic              boot_done,
   output logic              boot_err
);

   localparam int unsigned DIV       = (CLK_FREQ + BAUD / 2) / BAUD;
   localparam int unsigned HALF      = DIV / 2;
   localparam int unsigned CNT_W     = $clog2(DIV + 1);
   localparam int unsigned MAX_WORDS = 32'd1 << ADDR_W;

   // ---------------- RX front end ----------------
   typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

   rx_state_t        rx_state_q, rx_state_d;
   logic [1:0]       rx_sync_q;
   logic             rx_prev_q;
   logic [CNT_W-1:0] rx_cnt_q, rx_cnt_d;
   logic [2:0]       rx_bit_q, rx_bit_d;
   logic [7:0]       rx_sh_q, rx_sh_d;
   logic [7:0]       rx_byte_q, rx_byte_d;
   logic             rx_valid_q, rx_valid_d;
   logic             rx_ferr_q, rx_ferr_d;
   logic             rx_in;

   assign rx_in = rx_sync_q[1];

   always_ff @(posedge clk) begin
      if (!rst) begin
         rx_sync_q  <= 2'b11;
         rx_prev_q  <= 1'b1;
         rx_state_q <= RX_IDLE;
         rx_cnt_q   <= '0;
         rx_bit_q   <= '0;
         rx_sh_q    <= '0;
         rx_byte_q  <= '0;
         rx_valid_q <= 1'b0;
         rx_ferr_q  <= 1'b0;
      end else begin
         rx_sync_q  <= {rx_sync_q[0], uart_rx};
         rx_prev_q  <= rx_sync_q[1];
         rx_state_q <= rx_state_d;
         rx_cnt_q   <= rx_cnt_d;
         rx_bit_q   <= rx_bit_d;
         rx_sh_q    <= rx_sh_d;
         rx_byte_q  <= rx_byte_d;
         rx_valid_q <= rx_valid_d;
         rx_ferr_q  <= rx_ferr_d;
      end
   end

   // Bit timer: start bit checked at half period, data and stop at full periods after that
   always_comb begin
      rx_state_d = rx_state_q;
      rx_cnt_d   = rx_cnt_q + CNT_W'(1);
      rx_bit_d   = rx_bit_q;
      rx_sh_d    = rx_sh_q;
      rx_byte_d  = rx_byte_q;
      rx_valid_d = 1'b0;
      rx_ferr_d  = 1'b0;
      case (rx_state_q)
         RX_IDLE: begin
            rx_cnt_d = '0;
            if (rx_prev_q && !rx_in) rx_state_d = RX_START;
         end
         RX_START: begin
            if (rx_cnt_q == CNT_W'(HALF - 1)) begin
               rx_cnt_d = '0;
               rx_bit_d = '0;
               rx_state_d = rx_in ? RX_IDLE : RX_DATA;
            end
         end
         RX_DATA: begin
            if (rx_cnt_q == CNT_W'(DIV - 1)) begin
               rx_cnt_d = '0;
               rx_sh_d  = {rx_in, rx_sh_q[7:1]};
               rx_bit_d = rx_bit_q + 3'd1;
               if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
            end
         end
         RX_STOP: begin
            if (rx_cnt_q == CNT_W'(DIV - 1)) begin
               rx_cnt_d   = '0;
               rx_state_d = RX_IDLE;
               if (rx_in) begin
                  rx_valid_d = 1'b1;
                  rx_byte_d  = rx_sh_q;
               end else begin
                  rx_ferr_d = 1'b1;
               end
            end
         end
         default: rx_state_d = RX_IDLE;
      endcase
   end

   // ---------------- Load protocol FSM ----------------
   typedef enum logic [2:0] {
      S_IDLE, S_LEN_LO, S_LEN_HI, S_DATA, S_CSUM, S_DONE, S_ERR
   } boot_state_t;

   boot_state_t       state_q, state_d;
   logic [15:0]       count_q, count_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [23:0]       word_q, word_d;
   logic [1:0]        idx_q, idx_d;
   logic [7:0]        sum_q, sum_d;
   logic              we_q, we_d;
   logic [ADDR_W-1:0] waddr_q, waddr_d;
   logic [31:0]       wdata_q, wdata_d;
   logic              hold_q, hold_d;
   logic              done_q, done_d;
   logic              err_q, err_d;
   logic              sync_hit_c;
   logic [15:0]       len_c;

   assign sync_hit_c = rx_valid_q && (rx_byte_q == SYNC_BYTE);
   assign len_c      = {rx_byte_q, count_q[7:0]};

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= S_IDLE;
         count_q <= '0;
         addr_q  <= '0;
         word_q  <= '0;
         idx_q   <= '0;
         sum_q   <= '0;
         we_q    <= 1'b0;
         waddr_q <= '0;
         wdata_q <= '0;
         hold_q  <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         addr_q  <= addr_d;
         word_q  <= word_d;
         idx_q   <= idx_d;
         sum_q   <= sum_d;
         we_q    <= we_d;
         waddr_q <= waddr_d;
         wdata_q <= wdata_d;
         hold_q  <= hold_d;
         done_q  <= done_d;
         err_q   <= err_d;
      end
   end

   always_comb begin
      state_d = state_q;
      count_d = count_q;
      addr_d  = addr_q;
      word_d  = word_q;
      idx_d   = idx_q;
      sum_d   = sum_q;
      we_d    = 1'b0;
      waddr_d = waddr_q;
      wdata_d = wdata_q;
      hold_d  = hold_q;
      done_d  = done_q;
      err_d   = err_q;
      case (state_q)
         // DONE and ERR idle like IDLE; only a sync byte starts a new load
         S_IDLE, S_DONE, S_ERR: begin
            if (sync_hit_c) begin
               state_d = S_LEN_LO;
               hold_d  = 1'b1;
               done_d  = 1'b0;
               err_d   = 1'b0;
               addr_d  = '0;
               sum_d   = '0;
               idx_d   = '0;
            end
         end
         S_LEN_LO: begin
            if (rx_ferr_q) begin
               state_d = S_ERR;
               err_d   = 1'b1;
            end else if (rx_valid_q) begin
               count_d[7:0] = rx_byte_q;
               state_d      = S_LEN_HI;
            end
         end
         S_LEN_HI: begin
            if (rx_ferr_q) begin
               state_d = S_ERR;
               err_d   = 1'b1;
            end else if (rx_valid_q) begin
               count_d = len_c;
               if (len_c == 16'd0 || 32'(len_c) > MAX_WORDS) begin
                  state_d = S_ERR;
                  err_d   = 1'b1;
               end else begin
                  state_d = S_DATA;
               end
            end
         end
         S_DATA: begin
            if (rx_ferr_q) begin
               state_d = S_ERR;
               err_d   = 1'b1;
            end else if (rx_valid_q) begin
               sum_d  = sum_q + rx_byte_q;
               word_d = {rx_byte_q, word_q[23:8]};
               idx_d  = idx_q + 2'd1;
               if (idx_q == 2'd3) begin
                  we_d    = 1'b1;
                  waddr_d = addr_q;
                  wdata_d = {rx_byte_q, word_q};
                  addr_d  = addr_q + ADDR_W'(1);
                  if (32'(addr_q) + 32'd1 == 32'(count_q)) state_d = S_CSUM;
               end
            end
         end
         S_CSUM: begin
            if (rx_ferr_q) begin
               state_d = S_ERR;
               err_d   = 1'b1;
            end else if (rx_valid_q) begin
               if (rx_byte_q == sum_q) begin
                  state_d = S_DONE;
                  done_d  = 1'b1;
                  hold_d  = 1'b0;
               end else begin
                  state_d = S_ERR;
                  err_d   = 1'b1;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign imem_we    = we_q;
   assign imem_waddr = waddr_q;
   assign imem_wdata = wdata_q;
   assign cpu_hold   = hold_q;
   assign boot_done  = done_q;
   assign boot_err   = err_q;

`ifdef BOOT_ECHO_EN
   // ---------------- Echo transmitter ----------------
   typedef enum logic {TX_IDLE, TX_BUSY} tx_state_t;

   tx_state_t        tx_state_q, tx_state_d;
   logic [9:0]       tx_sh_q, tx_sh_d;
   logic [3:0]       tx_bit_q, tx_bit_d;
   logic [CNT_W-1:0] tx_cnt_q, tx_cnt_d;
   logic [7:0]       tx_hold_q, tx_hold_d;
   logic             tx_full_q, tx_full_d;

   always_ff @(posedge clk) begin
      if (!rst) begin
         tx_state_q <= TX_IDLE;
         tx_sh_q    <= '1;
         tx_bit_q   <= '0;
         tx_cnt_q   <= '0;
         tx_hold_q  <= '0;
         tx_full_q  <= 1'b0;
      end else begin
         tx_state_q <= tx_state_d;
         tx_sh_q    <= tx_sh_d;
         tx_bit_q   <= tx_bit_d;
         tx_cnt_q   <= tx_cnt_d;
         tx_hold_q  <= tx_hold_d;
         tx_full_q  <= tx_full_d;
      end
   end

   // A byte arriving while busy waits in the holding register; equal line rates bound the backlog to one
   always_comb begin
      tx_state_d = tx_state_q;
      tx_sh_d    = tx_sh_q;
      tx_bit_d   = tx_bit_q;
      tx_cnt_d   = tx_cnt_q;
      tx_hold_d  = tx_hold_q;
      tx_full_d  = tx_full_q;
      case (tx_state_q)
         TX_IDLE: begin
            if (rx_valid_q) begin
               tx_sh_d    = {1'b1, rx_byte_q, 1'b0};
               tx_state_d = TX_BUSY;
               tx_cnt_d   = '0;
               tx_bit_d   = '0;
            end else if (tx_full_q) begin
               tx_sh_d    = {1'b1, tx_hold_q, 1'b0};
               tx_full_d  = 1'b0;
               tx_state_d = TX_BUSY;
               tx_cnt_d   = '0;
               tx_bit_d   = '0;
            end
         end
         TX_BUSY: begin
            if (rx_valid_q) begin
               tx_hold_d = rx_byte_q;
               tx_full_d = 1'b1;
            end
            tx_cnt_d = tx_cnt_q + CNT_W'(1);
            if (tx_cnt_q == CNT_W'(DIV - 1)) begin
               tx_cnt_d = '0;
               tx_sh_d  = {1'b1, tx_sh_q[9:1]};
               if (tx_bit_q == 4'd9) begin
                  tx_state_d = TX_IDLE;
               end else begin
                  tx_bit_d = tx_bit_q + 4'd1;
               end
            end
         end
         default: tx_state_d = TX_IDLE;
      endcase
   end

   assign uart_tx = tx_sh_q[0];
`else
   assign uart_tx = 1'b1;
`endif

endmodule

// File: tb/tb_uart_boot_loader.sv
// Directed bench for uart_boot_loader: good/bad loads, count limits, glitch and framing errors.
// Runs at a reduced clock/baud (16 clocks per bit) to keep the simulation short.
module tb_uart_boot_loader;

   localparam int unsigned CLK_FREQ = 1000000;
   localparam int unsigned BAUD     = 62500;
   localparam int unsigned DIV      = 16;

   logic        clk = 1'b0;
   logic        rst;
   logic        uart_rx;
   logic        uart_tx;
   logic        imem_we;
   logic [10:0] imem_waddr;
   logic [31:0] imem_wdata;
   logic        cpu_hold;
   logic        boot_done;
   logic        boot_err;

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic [10:0] a;
      logic [31:0] d;
   } wr_t;

   wr_t        wr_q[$];
   logic [7:0] exp_echo[$];
   logic [7:0] got_echo[$];
   logic       we_prev = 1'b0, we_long = 1'b0;
   logic       done_prev = 1'b0, hold_prev = 1'b0;
   logic       mon_on = 1'b0, tx_low_seen = 1'b0;

   always #5 clk = ~clk;

   uart_boot_loader #(
      .CLK_FREQ (CLK_FREQ),
      .BAUD     (BAUD),
      .ADDR_W   (11),
      .SYNC_BYTE(8'hA5)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .uart_rx   (uart_rx),
      .uart_tx   (uart_tx),
      .imem_we   (imem_we),
      .imem_waddr(imem_waddr),
      .imem_wdata(imem_wdata),
      .cpu_hold  (cpu_hold),
      .boot_done (boot_done),
      .boot_err  (boot_err)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Write capture, strobe-width and done/hold edge monitor
   always @(negedge clk) begin
      if (mon_on) begin
         if (imem_we === 1'b1) wr_q.push_back('{a: imem_waddr, d: imem_wdata});
         if (imem_we === 1'b1 && we_prev) we_long = 1'b1;
         if (boot_done === 1'b1 && !done_prev)
            chk("done_edge_hold", {62'd0, hold_prev, cpu_hold}, 64'd2);
         if (uart_tx !== 1'b1) tx_low_seen = 1'b1;
         we_prev   = imem_we;
         done_prev = boot_done;
         hold_prev = cpu_hold;
      end
   end

`ifdef BOOT_ECHO_EN
   initial begin
      logic [7:0] b;
      forever begin
         @(negedge uart_tx);
         repeat (DIV / 2) @(negedge clk);
         for (int i = 0; i < 8; i++) begin
            repeat (DIV) @(negedge clk);
            b[i] = uart_tx;
         end
         repeat (DIV) @(negedge clk);
         got_echo.push_back(b);
      end
   end
`endif

   task automatic send_byte(input logic [7:0] b, input logic stop);
      uart_rx = 1'b0;
      repeat (DIV) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         uart_rx = b[i];
         repeat (DIV) @(negedge clk);
      end
      uart_rx = stop;
      repeat (DIV) @(negedge clk);
      uart_rx = 1'b1;
      repeat (4) @(negedge clk);
      if (stop) exp_echo.push_back(b);
   endtask

   // Two-word image; the eight payload bytes sum to 8'h4C
   task automatic send_image(input logic [7:0] csum);
      logic [7:0] fr [11];
      fr = '{8'hA5, 8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
      for (int i = 0; i < 11; i++) send_byte(fr[i], 1'b1);
      send_byte(csum, 1'b1);
   endtask

   initial begin
      rst     = 1'b0;
      uart_rx = 1'b1;
      repeat (3) @(negedge clk);
      chk("rst_we",    {63'd0, imem_we},    64'd0);
      chk("rst_waddr", {53'd0, imem_waddr}, 64'd0);
      chk("rst_wdata", {32'd0, imem_wdata}, 64'd0);
      chk("rst_hold",  {63'd0, cpu_hold},   64'd0);
      chk("rst_done",  {63'd0, boot_done},  64'd0);
      chk("rst_err",   {63'd0, boot_err},   64'd0);
      chk("rst_tx",    {63'd0, uart_tx},    64'd1);
      rst    = 1'b1;
      mon_on = 1'b1;
      repeat (100 * DIV) @(negedge clk);
      chk("idle_hold",   {63'd0, cpu_hold}, 64'd0);
      chk("idle_writes", 64'(wr_q.size()),  64'd0);

      // Good load, with hold checked mid-frame
      send_byte(8'hA5, 1'b1);
      chk("sync_hold", {63'd0, cpu_hold},  64'd1);
      chk("sync_done", {63'd0, boot_done}, 64'd0);
      send_byte(8'h02, 1'b1);
      send_byte(8'h00, 1'b1);
      send_byte(8'h78, 1'b1); send_byte(8'h56, 1'b1);
      send_byte(8'h34, 1'b1); send_byte(8'h12, 1'b1);
      chk("w0_writes", 64'(wr_q.size()),    64'd1);
      chk("w0_hold",   {63'd0, cpu_hold},   64'd1);
      send_byte(8'hEF, 1'b1); send_byte(8'hBE, 1'b1);
      send_byte(8'hAD, 1'b1); send_byte(8'hDE, 1'b1);
      chk("w1_hold",   {63'd0, cpu_hold},   64'd1);
      send_byte(8'h4C, 1'b1);
      chk("ok_writes", 64'(wr_q.size()),    64'd2);
      chk("ok_w0",     {21'd0, wr_q[0].a, wr_q[0].d}, {21'd0, 11'd0, 32'h12345678});
      chk("ok_w1",     {21'd0, wr_q[1].a, wr_q[1].d}, {21'd0, 11'd1, 32'hDEADBEEF});
      chk("ok_done",   {63'd0, boot_done},  64'd1);
      chk("ok_hold",   {63'd0, cpu_hold},   64'd0);
      chk("ok_err",    {63'd0, boot_err},   64'd0);
      chk("ok_waddr",  {53'd0, imem_waddr}, 64'd1);
      chk("ok_wdata",  {32'd0, imem_wdata}, 64'hDEADBEEF);

      // Bad checksum, then a clean reload
      send_image(8'h5D);
      chk("bad_err",    {63'd0, boot_err},  64'd1);
      chk("bad_hold",   {63'd0, cpu_hold},  64'd1);
      chk("bad_done",   {63'd0, boot_done}, 64'd0);
      chk("bad_writes", 64'(wr_q.size()),   64'd4);
      send_image(8'h4C);
      chk("re_err",    {63'd0, boot_err},  64'd0);
      chk("re_done",   {63'd0, boot_done}, 64'd1);
      chk("re_hold",   {63'd0, cpu_hold},  64'd0);
      chk("re_writes", 64'(wr_q.size()),   64'd6);
      chk("re_w5",     {21'd0, wr_q[5].a, wr_q[5].d}, {21'd0, 11'd1, 32'hDEADBEEF});

      // Non-sync byte then a 5-clock low glitch in IDLE
      send_byte(8'h33, 1'b1);
      uart_rx = 1'b0;
      repeat (5) @(negedge clk);
      uart_rx = 1'b1;
      repeat (3 * DIV) @(negedge clk);
      chk("gl_hold",   {63'd0, cpu_hold},  64'd0);
      chk("gl_done",   {63'd0, boot_done}, 64'd1);
      chk("gl_err",    {63'd0, boot_err},  64'd0);

      // Count 2048 is accepted; a framing error in DATA aborts
      send_byte(8'hA5, 1'b1); send_byte(8'h00, 1'b1); send_byte(8'h08, 1'b1);
      chk("c2048_err",  {63'd0, boot_err}, 64'd0);
      chk("c2048_hold", {63'd0, cpu_hold}, 64'd1);
      send_byte(8'h11, 1'b0);
      chk("ferr_err",  {63'd0, boot_err}, 64'd1);
      chk("ferr_hold", {63'd0, cpu_hold}, 64'd1);

      // Count 2049 and count 0 are rejected
      send_byte(8'hA5, 1'b1);
      chk("resync_err", {63'd0, boot_err}, 64'd0);
      send_byte(8'h01, 1'b1); send_byte(8'h08, 1'b1);
      chk("c2049_err",  {63'd0, boot_err}, 64'd1);
      chk("c2049_hold", {63'd0, cpu_hold}, 64'd1);
      send_byte(8'hA5, 1'b1); send_byte(8'h00, 1'b1); send_byte(8'h00, 1'b1);
      chk("c0_err",    {63'd0, boot_err}, 64'd1);
      chk("end_writes", 64'(wr_q.size()), 64'd6);
      chk("we_width",   {63'd0, we_long}, 64'd0);

      repeat (30 * DIV) @(negedge clk);
`ifdef BOOT_ECHO_EN
      chk("echo_count", 64'(got_echo.size()), 64'(exp_echo.size()));
      for (int i = 0; i < exp_echo.size(); i++)
         chk($sformatf("echo_%0d", i), {56'd0, got_echo[i]}, {56'd0, exp_echo[i]});
`else
      chk("tx_idle", {63'd0, tx_low_seen}, 64'd0);
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
